dmem_host_loader: RTL
=====================

Name: dmem_host_loader

Overview:
- Host-side counterpart to the processor core: loads an input image into data memory over a byte stream, releases the core to run, waits for its done flag, then streams a result window from data memory back out.
- Sits beside the core top level and owns the data-memory port whenever the core is held in reset.
- The data-memory mux select comes from this block.

Parameters:
AW, 8, data-memory address width
LOAD_BASE, 0, first data-memory address written during load
LOAD_LEN, 64, bytes accepted per load (1..2^AW)
RD_BASE, 64, first data-memory address read back
RD_LEN, 64, bytes streamed out per readback (1..2^AW)
TIMEOUT, 4095, max core run cycles before error (1..65535)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
go  input  1  start request; sampled only in IDLE/ERR
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader accepts in_data this cycle
out_valid  output  1  result byte valid
out_data  output  8  result byte
out_ready  input  1  host accepts out_data this cycle
mem_sel  output  1  1 = loader drives data-memory port, 0 = core drives it
mem_wr_en  output  1  data-memory write enable (loader side)
mem_addr  output  AW  data-memory address (loader side)
mem_wdata  output  8  data-memory write data
mem_rdata  input  8  data-memory read data (combinational read of mem_addr)
cpu_hold  output  1  1 = core held in reset
cpu_done  input  1  core done flag
busy  output  1  high in LOAD/RUN/READ
err  output  1  sticky run-timeout flag
run_cycles  output  16  core cycles counted in last run

Behaviour:
- Reset (async, reset=0): state IDLE, idx=0, run_cycles=0, err=0, cpu_hold=1, mem_sel=1, all other outputs 0.
- States: IDLE, LOAD, RUN, READ, FIN, ERR. busy=1 in LOAD/RUN/READ. cpu_hold=1 in every state except RUN. mem_sel = ~RUN.
- IDLE/ERR: on go=1, clear err, idx=0, run_cycles=0, go to LOAD next cycle. go is ignored in all other states.
- LOAD:
  - in_ready=1; mem_addr=LOAD_BASE+idx; mem_wdata=in_data; mem_wr_en=in_valid. Write and handshake happen in the same cycle.
  - On in_valid&in_ready: idx++. When the accepted byte is number LOAD_LEN, set idx=0 and go to RUN.
  - No write occurs while in_valid=0.
- RUN:
  - cpu_hold=0, mem_wr_en=0, in_ready=0. run_cycles increments every RUN cycle, saturating at 65535.
  - cpu_done is sampled from the 2nd RUN cycle onward. cpu_done=1 -> READ.
  - If run_cycles reaches TIMEOUT without done -> ERR with err=1. If done and timeout occur in the same cycle, done wins.
- READ:
  - mem_addr=RD_BASE+idx; out_data=mem_rdata (combinational); out_valid=1; mem_wr_en=0.
  - On out_valid&out_ready: idx++. After byte number RD_LEN is accepted -> FIN.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- FIN: one cycle, then IDLE. run_cycles holds its value until the next go.
- ERR: cpu_hold=1, err=1 until the next go; no stream activity.
- Address arithmetic is AW bits. LOAD_BASE+LOAD_LEN and RD_BASE+RD_LEN must not exceed 2^AW; the implementation adds a static assertion for this. No wrap occurs in legal configurations.
- Reset mid-operation: immediate return to reset values. Any partially loaded memory contents are left as is.

Test Plan:
- LOAD_LEN=4, RD_LEN=4, bytes 0x11,0x22,0x33,0x44 with in_valid continuous -> writes to addresses 0..3 in 4 consecutive cycles; RUN entered on the 5th cycle with cpu_hold=0.
- Same load with in_valid toggled 1,0,1,0 -> exactly 4 writes, to addresses 0..3 only on valid cycles.
- RUN with cpu_done raised after 10 cycles -> run_cycles=10, READ entered, mem_sel=1, cpu_hold=1.
- READ with memory 64..67 = 0xA0..0xA3 and out_ready stalled 3 cycles on byte 2 -> out_data held at 0xA2; 4 bytes delivered, then FIN, then IDLE.
- TIMEOUT=20 with cpu_done never asserted -> ERR after 20 RUN cycles, err=1, cpu_hold=1. A following go clears err and re-enters LOAD.
- reset asserted during READ mid-stream -> out_valid=0, cpu_hold=1, state IDLE immediately; go issued while in RUN is ignored.

Source files
------------

// File: rtl/dmem_host_loader_if.sv
// Host-side stream and data-memory port bundle for dmem_host_loader.
// The master modport is the loader. The slave modport is the host, stream and memory side.
interface dmem_host_loader_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;

    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;

    logic          mem_sel;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data,
        output mem_sel, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data,
        input  mem_sel, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_host_loader.sv
// Loads a byte image into data memory, lets the core run until it reports done,
// then streams a window of data memory back to the host.
module dmem_host_loader #(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int RD_BASE   = 64,
    parameter int RD_LEN    = 64,
    parameter int TIMEOUT   = 4095
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    dmem_host_loader_if.master  bus,
    output logic                cpu_hold,
    input  logic                cpu_done,
    output logic                busy,
    output logic                err,
    output logic [15:0]         run_cycles
);

    if (LOAD_LEN < 1 || RD_LEN < 1 || TIMEOUT < 1 || TIMEOUT > 65535 ||
        LOAD_BASE + LOAD_LEN > 2**AW || RD_BASE + RD_LEN > 2**AW) begin : g_bad_params
        $error("dmem_host_loader: load/readback window or timeout out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_READ, S_FIN, S_ERR} state_t;

    typedef struct packed {
        logic busy;
        logic cpu_hold;
        logic mem_sel;
        logic in_ready;
        logic out_valid;
    } flags_t;

    localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0] RD_BASE_A   = AW'(RD_BASE);
    localparam logic [AW-1:0] LOAD_LAST   = AW'(LOAD_LEN - 1);
    localparam logic [AW-1:0] RD_LAST     = AW'(RD_LEN - 1);
    localparam logic [15:0]   TIMEOUT_C   = 16'(TIMEOUT);

    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f.busy      = (s == S_LOAD) || (s == S_RUN) || (s == S_READ);
        f.cpu_hold  = (s != S_RUN);
        f.mem_sel   = (s != S_RUN);
        f.in_ready  = (s == S_LOAD);
        f.out_valid = (s == S_READ);
        return f;
    endfunction

    state_t        state;
    flags_t        flags;
    logic [AW-1:0] idx;
    logic [15:0]   rc_next;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = flags.in_ready & bus.in_valid;
    assign out_fire = flags.out_valid & bus.out_ready;
    assign rc_next  = (&run_cycles) ? run_cycles : run_cycles + 16'd1;

    // NOTE: the status flags are registered together with the state they decode,
    // so every transition loads flags_of(<next state>) in the same assignment.
    // Data memory itself lives outside this block and is never cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            flags      <= flags_of(S_IDLE);
            idx        <= '0;
            run_cycles <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (go) begin
                        state      <= S_LOAD;
                        flags      <= flags_of(S_LOAD);
                        idx        <= '0;
                        run_cycles <= '0;
                        err        <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        if (idx == LOAD_LAST) begin
                            idx   <= '0;
                            state <= S_RUN;
                            flags <= flags_of(S_RUN);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    run_cycles <= rc_next;
                    // run_cycles is still zero only on the first RUN cycle, where done is ignored
                    if (cpu_done && run_cycles != '0) begin
                        state <= S_READ;
                        flags <= flags_of(S_READ);
                    end else if (rc_next >= TIMEOUT_C) begin
                        state <= S_ERR;
                        flags <= flags_of(S_ERR);
                        err   <= 1'b1;
                    end
                end
                S_READ: begin
                    if (out_fire) begin
                        if (idx == RD_LAST) begin
                            idx   <= '0;
                            state <= S_FIN;
                            flags <= flags_of(S_FIN);
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    flags <= flags_of(S_IDLE);
                end
                default: begin
                    state <= S_IDLE;
                    flags <= flags_of(S_IDLE);
                end
            endcase
        end
    end

    // NOTE: a default assignment comes first so no path through this block infers a latch.
    always_comb begin
        bus.mem_addr = '0;
        if (flags.in_ready) begin
            bus.mem_addr = LOAD_BASE_A + idx;
        end else if (flags.out_valid) begin
            bus.mem_addr = RD_BASE_A + idx;
        end
    end

    assign busy          = flags.busy;
    assign cpu_hold      = flags.cpu_hold;
    assign bus.mem_sel   = flags.mem_sel;
    assign bus.in_ready  = flags.in_ready;
    assign bus.out_valid = flags.out_valid;
    assign bus.mem_wr_en = in_fire;
    assign bus.mem_wdata = flags.in_ready ? bus.in_data : 8'h00;
    // The address is held while stalled, so the read byte stays stable until it is accepted.
    assign bus.out_data  = flags.out_valid ? bus.mem_rdata : 8'h00;

endmodule
